bids22_host: RTL and testbench
==============================

# bids22_host

Auction host sequencer: the initiator on the controller side of the bids22 auction interface. On each `cfg_go` request it drives `C_op`/`C_data`/`C_start` through a full round: unlock, load the three bidder balances, set mask, timer and bid charge, lock, run the round, then capture `maxBid` and the winner. It sits between the system's configuration logic and the bids22 auction core, and reports completion or abort with a cause.

## Interface
- `UNLOCK_KEY`, 32'h0F0F0F0F: key sent with Unlock and Lock commands.
- `WDOG_CYCLES`, 1024: maximum RUN-state cycles before timeout abort (only with `BIDS22_HOST_WDOG_EN`).
- `clk` in 1: clock, all state on rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `cfg_go` in 1: request a round; accepted only in IDLE.
- `cfg_xval`, `cfg_yval`, `cfg_zval` in 32 each: initial balances for X/Y/Z.
- `cfg_mask` in 3: bidder enable mask {X,Y,Z}.
- `cfg_timer` in 32: round timer value.
- `cfg_cost` in 32: per-bid charge.
- `abort` in 1: software abort, honoured in RUN only.
- `ready` in 1: auction core ready for a command.
- `err` in 2: auction core command status.
- `roundOver` in 1: auction round finished.
- `maxBid` in 32: winning bid amount.
- `X_win`, `Y_win`, `Z_win` in 1 each: winner flags.
- `C_op` out 4: command opcode to auction core.
- `C_data` out 32: command data.
- `C_start` out 1: round start/hold.
- `busy` out 1: high from accept of `cfg_go` until DONE/FAIL exit.
- `done` out 1: one-cycle pulse, round completed.
- `fail` out 1: one-cycle pulse, sequence aborted.
- `res_maxBid` out 32: captured `maxBid`.
- `res_win` out 3: captured {X_win,Y_win,Z_win}.
- `fail_op` out 4: opcode in flight at abort (0 for timeout/abort in RUN).
- `fail_err` out 2: `err` value at abort.
- `fail_timeout` out 1: abort caused by watchdog.

## Operation
- Opcodes: NoOp 0, Unlock 1, Lock 2, LoadX 3, LoadY 4, LoadZ 5, SetXYZmask 6, SetTimer 7, BidCharge 8.
- States: IDLE, UNLK, LDX, LDY, LDZ, MASK, TMR, COST, LOCK, CHK, RUN, DONE, FAIL.
- IDLE: on `cfg_go`=1, snapshot all `cfg_*` into internal registers, assert `busy`; go UNLK if internal `locked`=1, else LDX.
- Command states: hold `C_op`=NoOp while `ready`=0; when `ready`=1 drive opcode + data for exactly one cycle, then CHK with return pointer to the next command state.
- Data: Unlock/Lock carry `UNLOCK_KEY`; LoadX/Y/Z carry snapshot balances; SetXYZmask carries {29'b0, mask}; SetTimer timer; BidCharge cost.
- CHK: `C_op`=NoOp; sample `err`. `err`=00 → next state. `err`=2'b10 after Unlock → benign, continue. Any other nonzero → FAIL, latch `fail_op`, `fail_err`.
- `locked` set on successful Lock check, cleared on successful Unlock check; reset clears it.
- Order: [UNLK] → LDX → LDY → LDZ → MASK → TMR → COST → LOCK → RUN.
- RUN: `C_start`=1, `C_op`=NoOp. On `roundOver`=1 capture `res_maxBid`, `res_win`, go DONE. `abort`=1 (no `roundOver` same cycle) → FAIL with `fail_op`=0, `fail_err`=0.
- `roundOver` and `abort` in same cycle: `roundOver` wins.
- DONE: `C_start`=0, `done`=1 one cycle, `busy`=0 next cycle, → IDLE. FAIL: same with `fail`=1.
- `cfg_go` while busy ignored; results/fail fields hold until next accepted `cfg_go`, which clears fail fields.

## Timing
- Reset values: `C_op`=0, `C_data`=0, `C_start`=0, `busy`=0, `done`=0, `fail`=0, `res_maxBid`=0, `res_win`=0, `fail_op`=0, `fail_err`=0, `fail_timeout`=0; state IDLE, `locked`=0.
- Reset mid-sequence: immediate return to reset values; `C_start` drops asynchronously.
- Each command: 1 drive cycle + 1 check cycle minimum; `ready` stalls add cycles.
- Fresh sequence with `ready`=1 throughout, unlocked: `C_start` rises 14 cycles after `cfg_go` sampled.
- `done` asserts the cycle after `roundOver` is sampled; `C_start` deasserts that same cycle.
- All outputs registered.

## Configuration
- `BIDS22_HOST_WDOG_EN` defined: 32-bit counter clears on RUN entry, increments each RUN cycle; reaching `WDOG_CYCLES` without `roundOver` → FAIL, `fail_timeout`=1.
- Undefined: no counter; RUN waits indefinitely for `roundOver` or `abort`; `fail_timeout` tied 0.

## Test plan
- Reset, `cfg_go` with xval=100, yval=200, zval=300, mask=3'b111, timer=50, cost=1, `ready`=1, `err`=0 → ops 3,4,5,6,7,8,2 on alternating cycles, `C_start`=1 at cycle 14.
- Model asserts `roundOver` with `maxBid`=42, `Y_win`=1 → `res_maxBid`=42, `res_win`=3'b010, `done` one cycle, `C_start`=0.
- Second `cfg_go` after success → first op is Unlock with `C_data`=32'h0F0F0F0F; `err`=2'b10 there → sequence continues.
- `err`=2'b01 in CHK after LoadY → `fail` pulse, `fail_op`=4, `fail_err`=01, `C_start` never asserted.
- `ready`=0 for 5 cycles before SetTimer → `C_op` held 0, SetTimer issued once when `ready` rises.
- With `BIDS22_HOST_WDOG_EN`, `WDOG_CYCLES`=16, no `roundOver` → `fail`, `fail_timeout`=1 after 16 RUN cycles; reset asserted mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/bids22_host.sv
// rtl/bids22_host.sv - bids22 auction host sequencer: unlock, load, configure, lock, run, capture.
// Optional RUN-state watchdog enabled by defining BIDS22_HOST_WDOG_EN.
module bids22_host #(
  parameter logic [31:0] UNLOCK_KEY = 32'h0F0F0F0F
`ifdef BIDS22_HOST_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_go,
  input  logic [31:0] cfg_xval,
  input  logic [31:0] cfg_yval,
  input  logic [31:0] cfg_zval,
  input  logic [2:0]  cfg_mask,
  input  logic [31:0] cfg_timer,
  input  logic [31:0] cfg_cost,
  input  logic        abort,
  input  logic        ready,
  input  logic [1:0]  err,
  input  logic        roundOver,
  input  logic [31:0] maxBid,
  input  logic        X_win,
  input  logic        Y_win,
  input  logic        Z_win,
  output logic [3:0]  C_op,
  output logic [31:0] C_data,
  output logic        C_start,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [31:0] res_maxBid,
  output logic [2:0]  res_win,
  output logic [3:0]  fail_op,
  output logic [1:0]  fail_err,
  output logic        fail_timeout
);

  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_LOADX  = 4'd3;
  localparam logic [3:0] OP_LOADY  = 4'd4;
  localparam logic [3:0] OP_LOADZ  = 4'd5;
  localparam logic [3:0] OP_MASK   = 4'd6;
  localparam logic [3:0] OP_TIMER  = 4'd7;
  localparam logic [3:0] OP_COST   = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE, S_UNLK, S_LDX, S_LDY, S_LDZ, S_MASK, S_TMR, S_COST,
    S_LOCK, S_CHK, S_RUN, S_DONE, S_FAIL
  } state_t;

  state_t      state, state_n;
  state_t      ret_state, ret_n;
  logic        locked, locked_n;
  logic [31:0] snap_x, snap_x_n;
  logic [31:0] snap_y, snap_y_n;
  logic [31:0] snap_z, snap_z_n;
  logic [2:0]  snap_mask, snap_mask_n;
  logic [31:0] snap_timer, snap_timer_n;
  logic [31:0] snap_cost, snap_cost_n;

  logic [3:0]  op_n;
  logic [31:0] data_n;
  logic        start_n, busy_n, done_n, fail_n;
  logic [31:0] res_max_n;
  logic [2:0]  res_win_n;
  logic [3:0]  fail_op_n;
  logic [1:0]  fail_err_n;

  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;
  state_t      cmd_ret;

`ifdef BIDS22_HOST_WDOG_EN
  logic [31:0] wdog_cnt, wdog_cnt_n;
  logic        timeout_n;
`endif

  // Opcode, payload and follow-on state for whichever command state is current.
  always_comb begin
    cmd_op   = OP_NOOP;
    cmd_data = '0;
    cmd_ret  = S_IDLE;
    case (state)
      S_UNLK: begin cmd_op = OP_UNLOCK; cmd_data = UNLOCK_KEY;            cmd_ret = S_LDX;  end
      S_LDX:  begin cmd_op = OP_LOADX;  cmd_data = snap_x;                cmd_ret = S_LDY;  end
      S_LDY:  begin cmd_op = OP_LOADY;  cmd_data = snap_y;                cmd_ret = S_LDZ;  end
      S_LDZ:  begin cmd_op = OP_LOADZ;  cmd_data = snap_z;                cmd_ret = S_MASK; end
      S_MASK: begin cmd_op = OP_MASK;   cmd_data = {29'b0, snap_mask};    cmd_ret = S_TMR;  end
      S_TMR:  begin cmd_op = OP_TIMER;  cmd_data = snap_timer;            cmd_ret = S_COST; end
      S_COST: begin cmd_op = OP_COST;   cmd_data = snap_cost;             cmd_ret = S_LOCK; end
      S_LOCK: begin cmd_op = OP_LOCK;   cmd_data = UNLOCK_KEY;            cmd_ret = S_RUN;  end
      default: ;
    endcase
  end

  always_comb begin
    state_n      = state;
    ret_n        = ret_state;
    locked_n     = locked;
    snap_x_n     = snap_x;
    snap_y_n     = snap_y;
    snap_z_n     = snap_z;
    snap_mask_n  = snap_mask;
    snap_timer_n = snap_timer;
    snap_cost_n  = snap_cost;
    op_n         = OP_NOOP;
    data_n       = '0;
    start_n      = C_start;
    busy_n       = busy;
    done_n       = 1'b0;
    fail_n       = 1'b0;
    res_max_n    = res_maxBid;
    res_win_n    = res_win;
    fail_op_n    = fail_op;
    fail_err_n   = fail_err;
`ifdef BIDS22_HOST_WDOG_EN
    wdog_cnt_n   = wdog_cnt;
    timeout_n    = fail_timeout;
`endif
    case (state)
      S_IDLE: begin
        if (cfg_go) begin
          snap_x_n     = cfg_xval;
          snap_y_n     = cfg_yval;
          snap_z_n     = cfg_zval;
          snap_mask_n  = cfg_mask;
          snap_timer_n = cfg_timer;
          snap_cost_n  = cfg_cost;
          busy_n       = 1'b1;
          fail_op_n    = OP_NOOP;
          fail_err_n   = 2'b00;
`ifdef BIDS22_HOST_WDOG_EN
          timeout_n    = 1'b0;
`endif
          state_n      = locked ? S_UNLK : S_LDX;
        end
      end
      S_UNLK, S_LDX, S_LDY, S_LDZ, S_MASK, S_TMR, S_COST, S_LOCK: begin
        if (ready) begin
          op_n    = cmd_op;
          data_n  = cmd_data;
          ret_n   = cmd_ret;
          state_n = S_CHK;
        end
      end
      S_CHK: begin
        // C_op still shows the command under check; a "10" status on Unlock means already unlocked.
        if (err == 2'b00 || (err == 2'b10 && C_op == OP_UNLOCK)) begin
          if (C_op == OP_LOCK)   locked_n = 1'b1;
          if (C_op == OP_UNLOCK) locked_n = 1'b0;
          state_n = ret_state;
          if (ret_state == S_RUN) begin
            start_n = 1'b1;
`ifdef BIDS22_HOST_WDOG_EN
            wdog_cnt_n = '0;
`endif
          end
        end else begin
          fail_op_n  = C_op;
          fail_err_n = err;
          fail_n     = 1'b1;
          state_n    = S_FAIL;
        end
      end
      S_RUN: begin
        if (roundOver) begin
          res_max_n = maxBid;
          res_win_n = {X_win, Y_win, Z_win};
          start_n   = 1'b0;
          done_n    = 1'b1;
          state_n   = S_DONE;
        end else if (abort) begin
          fail_op_n  = OP_NOOP;
          fail_err_n = 2'b00;
          start_n    = 1'b0;
          fail_n     = 1'b1;
          state_n    = S_FAIL;
        end
`ifdef BIDS22_HOST_WDOG_EN
        else if (wdog_cnt == 32'(WDOG_CYCLES - 1)) begin
          fail_op_n  = OP_NOOP;
          fail_err_n = 2'b00;
          timeout_n  = 1'b1;
          start_n    = 1'b0;
          fail_n     = 1'b1;
          state_n    = S_FAIL;
        end else begin
          wdog_cnt_n = wdog_cnt + 32'd1;
        end
`endif
      end
      S_DONE, S_FAIL: begin
        start_n = 1'b0;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      locked     <= 1'b0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_z     <= '0;
      snap_mask  <= '0;
      snap_timer <= '0;
      snap_cost  <= '0;
      C_op       <= OP_NOOP;
      C_data     <= '0;
      C_start    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      res_maxBid <= '0;
      res_win    <= '0;
      fail_op    <= '0;
      fail_err   <= '0;
    end else begin
      state      <= state_n;
      ret_state  <= ret_n;
      locked     <= locked_n;
      snap_x     <= snap_x_n;
      snap_y     <= snap_y_n;
      snap_z     <= snap_z_n;
      snap_mask  <= snap_mask_n;
      snap_timer <= snap_timer_n;
      snap_cost  <= snap_cost_n;
      C_op       <= op_n;
      C_data     <= data_n;
      C_start    <= start_n;
      busy       <= busy_n;
      done       <= done_n;
      fail       <= fail_n;
      res_maxBid <= res_max_n;
      res_win    <= res_win_n;
      fail_op    <= fail_op_n;
      fail_err   <= fail_err_n;
    end
  end

`ifdef BIDS22_HOST_WDOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt     <= '0;
      fail_timeout <= 1'b0;
    end else begin
      wdog_cnt     <= wdog_cnt_n;
      fail_timeout <= timeout_n;
    end
  end
`else
  assign fail_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bids22_host.sv
// tb/tb_bids22_host.sv - directed self-checking bench for bids22_host.
// Watchdog scenario runs only when BIDS22_HOST_WDOG_EN is defined.
module tb_bids22_host;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_go = 1'b0;
  logic [31:0] cfg_xval = '0, cfg_yval = '0, cfg_zval = '0;
  logic [2:0]  cfg_mask = '0;
  logic [31:0] cfg_timer = '0, cfg_cost = '0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic [1:0]  err = 2'b00;
  logic        roundOver = 1'b0;
  logic [31:0] maxBid = '0;
  logic        X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start, busy, done, fail;
  logic [31:0] res_maxBid;
  logic [2:0]  res_win;
  logic [3:0]  fail_op;
  logic [1:0]  fail_err;
  logic        fail_timeout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bids22_host #(
    .UNLOCK_KEY(32'h0F0F0F0F)
`ifdef BIDS22_HOST_WDOG_EN
    , .WDOG_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_go(cfg_go),
    .cfg_xval(cfg_xval), .cfg_yval(cfg_yval), .cfg_zval(cfg_zval),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost),
    .abort(abort), .ready(ready), .err(err), .roundOver(roundOver),
    .maxBid(maxBid), .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
    .C_op(C_op), .C_data(C_data), .C_start(C_start), .busy(busy),
    .done(done), .fail(fail), .res_maxBid(res_maxBid), .res_win(res_win),
    .fail_op(fail_op), .fail_err(fail_err), .fail_timeout(fail_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    total++; if ({C_op, C_data, C_start, busy, done, fail} !== 40'd0) begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", {C_op, C_data, C_start, busy, done, fail}); end
    total++; if ({res_maxBid, res_win, fail_op, fail_err, fail_timeout} !== 42'd0) begin bad++; $display("FAIL reset_res got=%0h exp=0", {res_maxBid, res_win, fail_op, fail_err, fail_timeout}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fresh_sequence();
    logic [3:0]  exp_op [7] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
    logic [31:0] exp_d  [7] = '{32'd100, 32'd200, 32'd300, 32'd7, 32'd50, 32'd1, 32'h0F0F0F0F};
    logic [3:0]  eo;
    cfg_xval = 32'd100; cfg_yval = 32'd200; cfg_zval = 32'd300;
    cfg_mask = 3'b111; cfg_timer = 32'd50; cfg_cost = 32'd1;
    ready = 1'b1; err = 2'b00;
    go();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fresh_busy got=%0b exp=1", busy); end
    for (int k = 1; k <= 14; k++) begin
      tick();
      eo = (k % 2 == 1) ? exp_op[(k - 1) / 2] : 4'd0;
      total++; if (C_op !== eo) begin bad++; $display("FAIL fresh_op cyc=%0d got=%0d exp=%0d", k, C_op, eo); end
      if (k % 2 == 1) begin
        total++; if (C_data !== exp_d[(k - 1) / 2]) begin bad++; $display("FAIL fresh_data cyc=%0d got=%0h exp=%0h", k, C_data, exp_d[(k - 1) / 2]); end
      end
      total++; if (C_start !== (k == 14)) begin bad++; $display("FAIL fresh_start cyc=%0d got=%0b exp=%0b", k, C_start, (k == 14)); end
    end
  endtask

  task automatic test_round_done();
    tick();
    tick();
    total++; if ({C_start, done} !== 2'b10) begin bad++; $display("FAIL run_hold got=%0b exp=10", {C_start, done}); end
    roundOver = 1'b1; maxBid = 32'd42; Y_win = 1'b1;
    tick();
    roundOver = 1'b0; maxBid = 32'd0; Y_win = 1'b0;
    total++; if ({done, C_start, busy} !== 3'b101) begin bad++; $display("FAIL done_pulse got=%0b exp=101", {done, C_start, busy}); end
    total++; if (res_maxBid !== 32'd42) begin bad++; $display("FAIL res_maxbid got=%0d exp=42", res_maxBid); end
    total++; if (res_win !== 3'b010) begin bad++; $display("FAIL res_win got=%0b exp=010", res_win); end
    tick();
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL done_exit got=%0b exp=00", {done, busy}); end
    total++; if (res_maxBid !== 32'd42) begin bad++; $display("FAIL res_hold got=%0d exp=42", res_maxBid); end
  endtask

  task automatic test_unlock_benign();
    go();
    tick();
    total++; if (C_op !== 4'd1) begin bad++; $display("FAIL unlock_op got=%0d exp=1", C_op); end
    total++; if (C_data !== 32'h0F0F0F0F) begin bad++; $display("FAIL unlock_data got=%0h exp=f0f0f0f", C_data); end
    err = 2'b10;
    tick();
    err = 2'b00;
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL unlock_benign got=%0b exp=0", fail); end
    tick();
    total++; if (C_op !== 4'd3) begin bad++; $display("FAIL unlock_next got=%0d exp=3", C_op); end
    for (int i = 0; i < 40 && C_start !== 1'b1; i++) tick();
    total++; if (C_start !== 1'b1) begin bad++; $display("FAIL unlock_run got=%0b exp=1", C_start); end
    roundOver = 1'b1; maxBid = 32'd9; X_win = 1'b1;
    tick();
    roundOver = 1'b0; X_win = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL unlock_done got=%0b exp=1", done); end
    tick();
  endtask

  task automatic test_err_after_loady();
    logic started = 1'b0;
    go();
    for (int i = 0; i < 20 && C_op !== 4'd4; i++) begin
      tick();
      if (C_start === 1'b1) started = 1'b1;
    end
    total++; if (C_op !== 4'd4) begin bad++; $display("FAIL erry_reach got=%0d exp=4", C_op); end
    err = 2'b01;
    tick();
    err = 2'b00;
    total++; if (fail !== 1'b1) begin bad++; $display("FAIL erry_fail got=%0b exp=1", fail); end
    total++; if (fail_op !== 4'd4) begin bad++; $display("FAIL erry_op got=%0d exp=4", fail_op); end
    total++; if (fail_err !== 2'b01) begin bad++; $display("FAIL erry_err got=%0b exp=01", fail_err); end
    if (C_start === 1'b1) started = 1'b1;
    tick();
    total++; if ({fail, busy} !== 2'b00) begin bad++; $display("FAIL erry_exit got=%0b exp=00", {fail, busy}); end
    tick();
    tick();
    total++; if ({fail_op, fail_err} !== 6'b0100_01) begin bad++; $display("FAIL erry_hold got=%0b exp=010001", {fail_op, fail_err}); end
    total++; if (started !== 1'b0) begin bad++; $display("FAIL erry_nostart got=%0b exp=0", started); end
  endtask

  task automatic test_ready_stall_abort();
    go();
    cfg_timer = 32'd999;
    total++; if ({fail_op, fail_err} !== 6'd0) begin bad++; $display("FAIL go_clears got=%0b exp=0", {fail_op, fail_err}); end
    for (int i = 0; i < 20 && C_op !== 4'd6; i++) tick();
    total++; if (C_op !== 4'd6) begin bad++; $display("FAIL stall_reach got=%0d exp=6", C_op); end
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (C_op !== 4'd0) begin bad++; $display("FAIL stall_hold i=%0d got=%0d exp=0", i, C_op); end
    end
    ready = 1'b1;
    tick();
    total++; if (C_op !== 4'd7) begin bad++; $display("FAIL stall_issue got=%0d exp=7", C_op); end
    total++; if (C_data !== 32'd50) begin bad++; $display("FAIL stall_snap got=%0d exp=50", C_data); end
    tick();
    total++; if (C_op !== 4'd0) begin bad++; $display("FAIL stall_once got=%0d exp=0", C_op); end
    tick();
    total++; if (C_op !== 4'd8) begin bad++; $display("FAIL stall_cost got=%0d exp=8", C_op); end
    cfg_timer = 32'd50;
    for (int i = 0; i < 20 && C_start !== 1'b1; i++) tick();
    total++; if (C_start !== 1'b1) begin bad++; $display("FAIL stall_run got=%0b exp=1", C_start); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if ({fail, done, C_start} !== 3'b100) begin bad++; $display("FAIL abort_pulse got=%0b exp=100", {fail, done, C_start}); end
    total++; if ({fail_op, fail_err} !== 6'd0) begin bad++; $display("FAIL abort_fields got=%0b exp=0", {fail_op, fail_err}); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_both_and_ignore();
    go();
    for (int i = 0; i < 40 && C_start !== 1'b1; i++) tick();
    total++; if (C_start !== 1'b1) begin bad++; $display("FAIL both_run got=%0b exp=1", C_start); end
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    total++; if ({C_start, busy, C_op} !== 6'b11_0000) begin bad++; $display("FAIL go_ignored got=%0b exp=110000", {C_start, busy, C_op}); end
    roundOver = 1'b1; abort = 1'b1; maxBid = 32'd7; X_win = 1'b1; Z_win = 1'b1;
    tick();
    roundOver = 1'b0; abort = 1'b0; maxBid = 32'd0; X_win = 1'b0; Z_win = 1'b0;
    total++; if ({done, fail} !== 2'b10) begin bad++; $display("FAIL both_wins got=%0b exp=10", {done, fail}); end
    total++; if ({res_maxBid, res_win} !== {32'd7, 3'b101}) begin bad++; $display("FAIL both_res got=%0d/%0b exp=7/101", res_maxBid, res_win); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    go();
    for (int i = 0; i < 40 && C_start !== 1'b1; i++) tick();
    total++; if (C_start !== 1'b1) begin bad++; $display("FAIL rst_run got=%0b exp=1", C_start); end
    #3;
    reset_n = 1'b0;
    #1;
    total++; if ({C_start, busy, C_op, res_maxBid, res_win} !== 41'd0) begin bad++; $display("FAIL rst_async got=%0h exp=0", {C_start, busy, C_op, res_maxBid, res_win}); end
    tick();
    reset_n = 1'b1;
    tick();
    go();
    tick();
    total++; if (C_op !== 4'd3) begin bad++; $display("FAIL rst_unlocked got=%0d exp=3", C_op); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

`ifdef BIDS22_HOST_WDOG_EN
  task automatic test_wdog();
    logic early = 1'b0;
    go();
    for (int i = 0; i < 40 && C_start !== 1'b1; i++) tick();
    total++; if (C_start !== 1'b1) begin bad++; $display("FAIL wdog_run got=%0b exp=1", C_start); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (fail === 1'b1) early = 1'b1;
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL wdog_early got=%0b exp=0", early); end
    tick();
    total++; if ({fail, fail_timeout, C_start} !== 3'b110) begin bad++; $display("FAIL wdog_fire got=%0b exp=110", {fail, fail_timeout, C_start}); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fresh_sequence();
    test_round_done();
    test_unlock_benign();
    test_err_after_loady();
    test_ready_stall_abort();
    test_both_and_ignore();
    test_reset_mid_run();
`ifdef BIDS22_HOST_WDOG_EN
    test_wdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
